// File: rtl/uart_pkg.sv
// Shared encodings and FSM state type for the UART transmit framer.
// Parity codes match the older combinational framer so configuration words carry over unchanged.
package uart_pkg;

    localparam logic [1:0] PAR_NONE  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE2 = 2'b11;

    localparam int MIN_LEN = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_frame_tx_if.sv
// Word/config handshake between the TX data source (master) and the framer (slave).
// Valid/ready: a transfer happens on a rising edge where din_valid and din_ready are both high;
// the master holds din and the config stable while din_valid is high, and ready may depend on state only.
interface uart_frame_tx_if #(
    parameter int DATA_MAX = 8,
    parameter int LEN_W    = $clog2(DATA_MAX + 1)
);
    logic [DATA_MAX-1:0] din;
    logic                din_valid;
    logic                din_ready;
    logic [LEN_W-1:0]    data_len;
    logic [1:0]          parity;
    logic                stop2;

    modport master (
        output din, din_valid, data_len, parity, stop2,
        input  din_ready
    );

    modport slave (
        input  din, din_valid, data_len, parity, stop2,
        output din_ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts CLKS_PER_BIT cycles while run is high, tick marks the last cycle.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = run && (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!run || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_frame_tx.sv
// UART transmit framer: latches one word plus frame config per handshake and serialises
// start, 5..DATA_MAX data bits LSB first, optional parity and 1 or 2 stop bits.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int DATA_MAX     = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int LEN_W        = $clog2(DATA_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx,
    uart_frame_tx_if.slave   bus,
    output logic             tx_out,
    output logic             busy,
    output logic             parity_bit,
    output state_t           state_o
);
    state_t              state_q, state_d;
    logic [DATA_MAX-1:0] shift_q, shift_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [1:0]          par_mode_q, par_mode_d;
    logic                stop2_q, stop2_d;
    logic                parity_bit_q, parity_bit_d;
    logic                tx_out_q, tx_out_d;
    logic [LEN_W-1:0]    len_clamped;
    logic                data_xor;
    logic                par_calc;
    logic                par_en;
    logic                accept;
    logic                tick;

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .run  (state_q != IDLE),
        .tick (tick)
    );

    assign accept = bus.din_valid & bus.din_ready;
    assign par_en = (par_mode_q == PAR_ODD) || (par_mode_q == PAR_EVEN);

    always_comb begin
        len_clamped = bus.data_len;
        if (bus.data_len < LEN_W'(MIN_LEN)) begin
            len_clamped = LEN_W'(MIN_LEN);
        end else if (bus.data_len > LEN_W'(DATA_MAX)) begin
            len_clamped = LEN_W'(DATA_MAX);
        end
    end

    // Parity covers only the bits that will actually be sent.
    always_comb begin
        data_xor = 1'b0;
        for (int i = 0; i < DATA_MAX; i++) begin
            if (LEN_W'(i) < len_clamped) begin
                data_xor = data_xor ^ bus.din[i];
            end
        end
        case (bus.parity)
            PAR_ODD:  par_calc = ~data_xor;
            PAR_EVEN: par_calc = data_xor;
            default:  par_calc = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (!tx) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:   if (accept) state_d = START;
                START:  if (tick) state_d = DATA;
                DATA:   if (tick && bit_cnt_q == len_q - LEN_W'(1)) state_d = par_en ? PARITY : STOP;
                PARITY: if (tick) state_d = STOP;
                STOP:   if (tick && bit_cnt_q == LEN_W'(stop2_q)) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        shift_d      = shift_q;
        len_d        = len_q;
        par_mode_d   = par_mode_q;
        stop2_d      = stop2_q;
        parity_bit_d = parity_bit_q;
        bit_cnt_d    = bit_cnt_q;
        if (accept) begin
            shift_d      = bus.din;
            len_d        = len_clamped;
            par_mode_d   = bus.parity;
            stop2_d      = bus.stop2;
            parity_bit_d = par_calc;
        end else if (state_q == DATA && tick) begin
            shift_d = shift_q >> 1;
        end
        if (state_d != state_q) begin
            bit_cnt_d = '0;
        end else if (tick && (state_q == DATA || state_q == STOP)) begin
            bit_cnt_d = bit_cnt_q + LEN_W'(1);
        end
    end

    // tx_out is computed from the next state so the registered line changes with the state.
    always_comb begin
        busy          = (state_q != IDLE);
        bus.din_ready = (state_q == IDLE) & tx & rst;
        case (state_d)
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = shift_d[0];
            PARITY:  tx_out_d = parity_bit_q;
            default: tx_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            len_q        <= '0;
            bit_cnt_q    <= '0;
            par_mode_q   <= PAR_NONE;
            stop2_q      <= 1'b0;
            parity_bit_q <= 1'b0;
            tx_out_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            len_q        <= len_d;
            bit_cnt_q    <= bit_cnt_d;
            par_mode_q   <= par_mode_d;
            stop2_q      <= stop2_d;
            parity_bit_q <= parity_bit_d;
            tx_out_q     <= tx_out_d;
        end
    end

    assign tx_out     = tx_out_q;
    assign parity_bit = parity_bit_q;
    assign state_o    = state_q;
endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx with CLKS_PER_BIT=4, DATA_MAX=8.
module tb_uart_frame_tx;
    import uart_pkg::*;

    localparam int DW  = 8;
    localparam int CPB = 4;
    localparam int LW  = 4;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    logic   tx  = 1'b0;
    logic   tx_out;
    logic   busy;
    logic   parity_bit;
    state_t state_o;

    uart_frame_tx_if #(.DATA_MAX(DW), .LEN_W(LW)) bus ();

    uart_frame_tx #(.DATA_MAX(DW), .CLKS_PER_BIT(CPB), .LEN_W(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx         (tx),
        .bus        (bus),
        .tx_out     (tx_out),
        .busy       (busy),
        .parity_bit (parity_bit),
        .state_o    (state_o)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_errors = 0;
    logic [0:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int eff_len(input int len);
        if (len < 5) return 5;
        if (len > DW) return DW;
        return len;
    endfunction

    function automatic logic ref_par(input logic [7:0] d, input int len, input logic [1:0] par);
        int ones = 0;
        for (int i = 0; i < eff_len(len); i++) ones += int'(d[i]);
        if (par == 2'b01) return (ones % 2 == 0);
        if (par == 2'b10) return (ones % 2 == 1);
        return 1'b0;
    endfunction

    task automatic push_frame(input logic [7:0] d, input int len, input logic [1:0] par,
                              input logic s2, output int nbits);
        int l = eff_len(len);
        exp_q.push_back(1'b0);
        for (int i = 0; i < l; i++) exp_q.push_back(d[i]);
        nbits = 1 + l + (s2 ? 2 : 1);
        if (par == 2'b01 || par == 2'b10) begin
            exp_q.push_back(ref_par(d, len, par));
            nbits++;
        end
        exp_q.push_back(1'b1);
        if (s2) exp_q.push_back(1'b1);
    endtask

    // ---------------- drivers ----------------
    task automatic drive_word(input logic [7:0] d, input int len, input logic [1:0] par,
                              input logic s2, output logic ok);
        int w = 0;
        @(negedge clk);
        bus.din       = d;
        bus.data_len  = LW'(len);
        bus.parity    = par;
        bus.stop2     = s2;
        bus.din_valid = 1'b1;
        while (!bus.din_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!bus.din_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            bus.din_valid = 1'b0;
            ok = 1'b0;
        end else begin
            @(posedge clk);
            #1 bus.din_valid = 1'b0;
            ok = 1'b1;
        end
    endtask

    task automatic recv_frame(input string tag, input int nbits);
        int   busy_cnt = 0;
        logic e;
        for (int i = 0; i < nbits * CPB; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (i % CPB == 1) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_queue_empty"}, 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("%s_bit%0d", tag, i / CPB), 32'(tx_out), 32'(e));
                end
            end
        end
        check({tag, "_busy_cycles"}, busy_cnt, nbits * CPB);
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_ready"}, 32'(bus.din_ready), 32'd1);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input int len,
                             input logic [1:0] par, input logic s2, input logic exp_par);
        int   nbits;
        logic ok;
        push_frame(d, len, par, s2, nbits);
        drive_word(d, len, par, s2, ok);
        if (ok) begin
            recv_frame(tag, nbits);
            check({tag, "_parity_bit"}, 32'(parity_bit), 32'(exp_par));
        end
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic       ok;
        logic       line_ok;
        logic [7:0] rd;
        int         rl;
        logic [1:0] rp;
        logic       rs;
        int         rise[2];
        int         n_rise;
        logic       prev_busy;
        int         w;

        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.data_len  = '0;
        bus.parity    = 2'b00;
        bus.stop2     = 1'b0;
        tx            = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_tx_out", 32'(tx_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(bus.din_ready), 32'd0);
        check("rst_parity", 32'(parity_bit), 32'd0);
        check("rst_state", 32'(state_o), 32'(IDLE));
        rst = 1'b1;
        @(negedge clk);

        run_frame("odd7s2",   8'hAB, 7, 2'b01, 1'b1, 1'b1);
        run_frame("even8",    8'hAB, 8, 2'b10, 1'b0, 1'b1);
        run_frame("odd8",     8'hAB, 8, 2'b01, 1'b0, 1'b0);
        run_frame("none00",   8'h6D, 8, 2'b00, 1'b0, 1'b0);
        run_frame("none11",   8'h6D, 8, 2'b11, 1'b0, 1'b0);
        run_frame("len3",     8'h6D, 3, 2'b00, 1'b0, 1'b0);
        run_frame("ff_odd7",  8'hFF, 7, 2'b01, 1'b0, 1'b0);
        run_frame("00_odd8",  8'h00, 8, 2'b01, 1'b0, 1'b1);
        run_frame("00_even8", 8'h00, 8, 2'b10, 1'b0, 1'b0);
        run_frame("len15",    8'hC3, 15, 2'b10, 1'b1, 1'b0);

        for (int k = 0; k < 4; k++) begin
            rd = 8'($urandom_range(0, 255));
            rl = $urandom_range(0, 9);
            rp = 2'($urandom_range(0, 3));
            rs = 1'($urandom_range(0, 1));
            run_frame($sformatf("rand%0d", k), rd, rl, rp, rs, ref_par(rd, rl, rp));
        end

        // Abort during DATA bit 3 (cycles 16..19 after accept)
        drive_word(8'hAB, 8, 2'b10, 1'b0, ok);
        repeat (17) @(negedge clk);
        check("abort_in_data", 32'(state_o), 32'(DATA));
        tx = 1'b0;
        @(negedge clk);
        check("abort_tx_out", 32'(tx_out), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(bus.din_ready), 32'd0);
        check("abort_state", 32'(state_o), 32'(IDLE));
        line_ok = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || busy !== 1'b0) line_ok = 1'b0;
        end
        check("abort_line_quiet", 32'(line_ok), 32'd1);
        check("abort_parity_hold", 32'(parity_bit), 32'd1);
        tx = 1'b1;
        @(negedge clk);
        check("resume_ready", 32'(bus.din_ready), 32'd1);
        run_frame("resume", 8'h3C, 6, 2'b01, 1'b1, 1'b1);

        // Reset during the stop bit: 0x55, len5, even -> 8 bits, STOP at cycles 28..31
        drive_word(8'h55, 5, 2'b10, 1'b0, ok);
        repeat (30) @(negedge clk);
        check("rst_mid_in_stop", 32'(state_o), 32'(STOP));
        check("rst_mid_parity_pre", 32'(parity_bit), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_tx_out", 32'(tx_out), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ready", 32'(bus.din_ready), 32'd0);
        check("rst_mid_parity", 32'(parity_bit), 32'd0);
        check("rst_mid_state", 32'(state_o), 32'(IDLE));
        rst = 1'b1;
        @(negedge clk);

        // Back-to-back with din_valid held: 0xAB len8 no parity 1 stop -> 10 bits
        bus.din       = 8'hAB;
        bus.data_len  = LW'(8);
        bus.parity    = 2'b00;
        bus.stop2     = 1'b0;
        bus.din_valid = 1'b1;
        n_rise    = 0;
        prev_busy = busy;
        for (int i = 0; i < 200 && n_rise < 2; i++) begin
            @(negedge clk);
            if (busy && !prev_busy) begin
                rise[n_rise] = i;
                n_rise++;
            end
            prev_busy = busy;
        end
        bus.din_valid = 1'b0;
        check("b2b_rises", n_rise, 2);
        if (n_rise == 2) check("b2b_spacing", rise[1] - rise[0], 10 * CPB + 1);
        w = 0;
        while (busy && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("b2b_drain", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Parametrised, clocked UART transmit framer and serializer. It accepts one data word per valid/ready handshake and latches the frame configuration with the word. It then drives a complete asynchronous frame onto a serial line: start bit, 5..DATA_MAX data bits LSB first, optional odd or even parity, and 1 or 2 stop bits. It sits between the TX data source and the pad. It supersedes the combinational Framer: it keeps that block's parity and stop-bit encodings and adds runtime data length, baud timing, flow control and frame abort.

## Interface
- DATA_MAX, default 8: widest data field in bits; legal range 5..9.
- CLKS_PER_BIT, default 16: clock cycles per serial bit; minimum 2.
- LEN_W, default $clog2(DATA_MAX+1): width of data_len.

- clk  in  1  sole clock; every flop is on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- tx  in  1  transmit enable. Low aborts any frame and holds the line idle.
- din  in  DATA_MAX  word to send; bit 0 is sent first.
- din_valid  in  1  din and config are valid.
- din_ready  out  1  block can accept a word this cycle.
- data_len  in  LEN_W  data bits per frame. Values below 5 are treated as 5; values above DATA_MAX are treated as DATA_MAX.
- parity  in  2  00 none, 01 odd, 10 even, 11 none.
- stop2  in  1  0 = one stop bit, 1 = two stop bits.
- tx_out  out  1  serial line; idle high.
- busy  out  1  a frame is in progress.
- parity_bit  out  1  parity of the latched frame; 0 when parity is none.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Handshake: a word is accepted when din_valid & din_ready. din_ready = (state==IDLE) & tx & rst.
- On accept, latch din, the clamped data_len, parity and stop2 into shadow registers. Input changes during the frame have no effect.
- Parity is computed over the low data_len bits of the latched word.
  - Odd: parity_bit = ~^bits.
  - Even: parity_bit = ^bits.
  - None (00 or 11): parity_bit = 0 and the PARITY state is skipped.
- State transitions:
  - IDLE → START on accept.
  - START → DATA.
  - DATA repeats until data_len bits are sent, then → PARITY, or → STOP if parity is none.
  - PARITY → STOP.
  - STOP lasts 1 or 2 bit periods, then → IDLE.
- Bit periods: every state except IDLE holds tx_out for exactly CLKS_PER_BIT cycles.
  - A baud counter runs from 0 to CLKS_PER_BIT-1 and reloads at each bit boundary.
  - A bit counter indexes DATA bits and STOP bits.
- tx_out levels: IDLE 1, START 0, DATA the shifted data bit, PARITY parity_bit, STOP 1. tx_out is registered (glitch-free).
- busy = (state != IDLE).
- Frame length in bits = 1 + len + (parity odd/even ? 1 : 0) + (stop2 ? 2 : 1). The range is 7..13 bits.
- Abort (tx low while busy):
  - Next edge: state → IDLE, tx_out = 1, busy = 0.
  - The word is dropped and the shadow registers are not cleared.
  - parity_bit holds its last value.
- tx low in IDLE: din_ready = 0 and no accept occurs.
- tx high again: normal operation resumes from IDLE. The dropped word is not retransmitted.
- Reset (rst low at an edge), in any state: state = IDLE, tx_out = 1, busy = 0, din_ready = 0, parity_bit = 0, and all counters are 0.
- Reset has priority over tx.

## Timing
- Accept at edge N: tx_out falls at edge N+1, and busy rises at N+1.
- Each bit lasts CLKS_PER_BIT cycles.
- The last stop bit ends at edge N+1+bits×CLKS_PER_BIT. At that edge, state = IDLE and din_ready = 1 (if tx is high).
- The minimum accept-to-accept spacing is bits×CLKS_PER_BIT + 1 cycles. The guaranteed idle gap between frames is 1 cycle.
- parity_bit is valid from edge N+1 until the next accept.
- Abort and reset both act one edge after they are sampled.

## Structure
- uart_pkg holds:
  - the parity encodings: PAR_NONE=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10, PAR_NONE2=2'b11;
  - the FSM state typedef;
  - the MIN_LEN=5 constant.
- One sub-module, uart_baud_tick, contains the CLKS_PER_BIT counter. It has inputs clk, rst and run, and an output tick that is high on the last cycle of each bit period.
- Parity, clamping and the shift register stay in the top level.

## Test plan
All scenarios use CLKS_PER_BIT=4 and DATA_MAX=8.
- Odd parity, 7 data bits, 2 stop bits: din=8'hAB, data_len=7, parity=01, stop2=1 → tx_out bit sequence 0,1,1,0,1,0,1,0,1,1,1; parity_bit=1; 44 busy cycles.
- Even parity, 8 data bits, 1 stop bit: din=8'hAB, data_len=8, parity=10, stop2=0 → sequence 0,1,1,0,1,0,1,0,1,1,1; parity_bit=1. Repeat with parity=01 → parity bit 0.
- No parity:
  - din=8'h6D, data_len=8, parity=00, stop2=0 → 10 bits: 0,1,0,1,1,0,1,1,0,1.
  - parity=11 gives an identical waveform.
  - data_len=3 behaves exactly as data_len=5.
- Extremes:
  - din=8'hFF, data_len=7, odd → parity_bit=0.
  - din=8'h00, data_len=8, odd → parity_bit=1.
  - din=8'h00, data_len=8, even → parity_bit=0.
- Abort and resume: pull tx low during DATA bit 3 → tx_out=1 and busy=0 on the next edge. No parity or stop bits appear. Raise tx → din_ready=1 next cycle, and the next word sends a complete frame.
- Reset mid-frame and back-to-back:
  - rst low in STOP → all outputs reach their reset values on the next edge.
  - With din_valid held high, two frames are spaced bits×4+1 cycles apart.
